// File: rtl/bcd_convert_seq.sv
// Multi-cycle bidirectional binary/BCD converter: double dabble (Mode 0) and
// reverse double dabble (Mode 1), with optional two's-complement sign/magnitude handling.
module bcd_convert_seq #(
   parameter int N      = 32,
   parameter int D      = (N + 2) / 3,
   parameter bit SIGNED = 1'b0
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic           Start,
   input  logic           Mode,
   input  logic [N-1:0]   V,
   input  logic [4*D-1:0] BcdIn,
   input  logic           SignIn,
   output logic           Ready,
   output logic           Done,
   output logic [4*D-1:0] BCD,
   output logic           Sign,
   output logic [N-1:0]   Bin,
   output logic           Overflow,
   output logic           Error
);

   localparam int W  = 4 * D;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          mode_q, sign_q, err_q;
   logic [W-1:0]  hi, lo;
   logic [W-1:0]  hi_adj, hi_shr, hi_sub, hi_step, lo_step;
   logic [N-1:0]  mag;
   logic [W:0]    lim;
   logic          bad_in, accept, last;

   // ---------------- FSM ----------------
   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = CONVERT;
         CONVERT: if (last)  state_nxt = DONE;
         DONE:    state_nxt = Start ? CONVERT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Ready = (state != CONVERT);
      Done  = (state == DONE);
   end

   assign accept = Start && (state != CONVERT);
   // cnt reaches K only on the edge after the K-th iteration: that edge registers results.
   assign last   = (cnt == (mode_q ? CW'(W) : CW'(N)));

   // ---------------- operand preparation ----------------
   always_comb begin
      mag = V;
      if (SIGNED && V[N-1]) mag = -V;
   end

   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < D; i++)
         if (BcdIn[4*i +: 4] > 4'd9) bad_in = 1'b1;
   end

   // Signed Mode 1 limit: 2^(N-1)-1 for positive results, 2^(N-1) for negative ones.
   always_comb begin
      lim = ({{W{1'b0}}, 1'b1} << (N - 1)) - (W + 1)'(1) + (W + 1)'(sign_q);
   end

   // ---------------- one iteration of either algorithm ----------------
   assign hi_shr = {1'b0, hi[W-1:1]};

   always_comb begin
      hi_adj = hi;
      hi_sub = hi_shr;
      for (int i = 0; i < D; i++) begin
         if (hi[4*i +: 4] >= 4'd5)     hi_adj[4*i +: 4] = hi[4*i +: 4] + 4'd3;
         if (hi_shr[4*i +: 4] >= 4'd8) hi_sub[4*i +: 4] = hi_shr[4*i +: 4] - 4'd3;
      end
   end

   always_comb begin
      if (mode_q) begin
         hi_step = hi_sub;
         lo_step = {hi[0], lo[W-1:1]};
      end else begin
         hi_step = {hi_adj[W-2:0], lo[N-1]};
         lo_step = {lo[W-2:0], 1'b0};
      end
   end

   // ---------------- datapath and result registers ----------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt      <= '0;
         mode_q   <= 1'b0;
         sign_q   <= 1'b0;
         err_q    <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         BCD      <= '0;
         Sign     <= 1'b0;
         Bin      <= '0;
         Overflow <= 1'b0;
         Error    <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         mode_q <= Mode;
         if (!Mode) begin
            hi     <= '0;
            lo     <= {{(W-N){1'b0}}, mag};
            sign_q <= SIGNED && V[N-1];
            err_q  <= 1'b0;
         end else begin
            hi     <= BcdIn;
            lo     <= '0;
            sign_q <= SIGNED && SignIn;
            err_q  <= bad_in;
         end
      end else if (state == CONVERT) begin
         if (!last) begin
            hi  <= hi_step;
            lo  <= lo_step;
            cnt <= cnt + CW'(1);
         end else if (!mode_q) begin
            BCD  <= hi;
            Sign <= sign_q;
         end else begin
            Error <= err_q;
            if (err_q) begin
               Bin      <= '0;
               Overflow <= 1'b0;
            end else if (SIGNED) begin
               Bin      <= sign_q ? -lo[N-1:0] : lo[N-1:0];
               Overflow <= ({1'b0, lo} > lim);
            end else begin
               Bin      <= lo[N-1:0];
               Overflow <= |lo[W-1:N];
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Bench for bcd_convert_seq: a 32-bit unsigned and an 8-bit signed instance,
// table-driven vectors checked through per-instance expectation queues.
module tb_bcd_convert_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk  = 0;
   int n_fail = 0;

   // 32-bit unsigned instance
   logic        rst32, start32, mode32, signin32;
   logic [31:0] v32;
   logic [43:0] bcdin32;
   logic        rdy32, done32, sign32, ovf32, err32;
   logic [43:0] bcd32;
   logic [31:0] bin32;

   // 8-bit signed instance
   logic        rst8, start8, mode8, signin8;
   logic [7:0]  v8;
   logic [11:0] bcdin8;
   logic        rdy8, done8, sign8, ovf8, err8;
   logic [11:0] bcd8;
   logic [7:0]  bin8;

   bcd_convert_seq #(.N(32), .SIGNED(1'b0)) u32 (
      .Clock(clk), .Reset(rst32), .Start(start32), .Mode(mode32), .V(v32),
      .BcdIn(bcdin32), .SignIn(signin32), .Ready(rdy32), .Done(done32),
      .BCD(bcd32), .Sign(sign32), .Bin(bin32), .Overflow(ovf32), .Error(err32)
   );

   bcd_convert_seq #(.N(8), .SIGNED(1'b1)) u8s (
      .Clock(clk), .Reset(rst8), .Start(start8), .Mode(mode8), .V(v8),
      .BcdIn(bcdin8), .SignIn(signin8), .Ready(rdy8), .Done(done8),
      .BCD(bcd8), .Sign(sign8), .Bin(bin8), .Overflow(ovf8), .Error(err8)
   );

   typedef struct {
      bit          sel;     // 0: u32, 1: u8s
      bit          mode;
      logic [31:0] v;
      logic [43:0] bcd_in;
      bit          sign_in;
      logic [43:0] e_bcd;
      bit          e_sign;
      logic [31:0] e_bin;
      bit          e_ovf;
      bit          e_err;
      int          due;     // cycle count at which Done must be seen
   } vec_t;

   vec_t vecs[$];
   vec_t q32[$];
   vec_t q8[$];
   vec_t e32, e8;

   function automatic vec_t mk(bit sel, bit mode, logic [31:0] v, logic [43:0] bi, bit si,
                               logic [43:0] eb, bit es, logic [31:0] ebin, bit eo, bit ee);
      vec_t t;
      t.sel = sel; t.mode = mode; t.v = v; t.bcd_in = bi; t.sign_in = si;
      t.e_bcd = eb; t.e_sign = es; t.e_bin = ebin; t.e_ovf = eo; t.e_err = ee; t.due = 0;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitors: compare on every Done pulse, sampled on the falling edge.
   always @(negedge clk) begin
      if (done32) begin
         if (q32.size() == 0) chk("u32_unexpected_done", done32, 0);
         else begin
            e32 = q32.pop_front();
            chk("u32_latency", cyc, e32.due);
            if (!e32.mode) begin
               chk("u32_bcd", bcd32, e32.e_bcd);
               chk("u32_sign", sign32, e32.e_sign);
            end else begin
               chk("u32_bin", bin32, e32.e_bin);
               chk("u32_ovf", ovf32, e32.e_ovf);
               chk("u32_err", err32, e32.e_err);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (done8) begin
         if (q8.size() == 0) chk("u8_unexpected_done", done8, 0);
         else begin
            e8 = q8.pop_front();
            chk("u8_latency", cyc, e8.due);
            if (!e8.mode) begin
               chk("u8_bcd", bcd8, e8.e_bcd);
               chk("u8_sign", sign8, e8.e_sign);
            end else begin
               chk("u8_bin", bin8, e8.e_bin);
               chk("u8_ovf", ovf8, e8.e_ovf);
               chk("u8_err", err8, e8.e_err);
            end
         end
      end
   end

   // Called on a falling edge; returns on the falling edge after the Start edge.
   task automatic drive(input vec_t t, input bit push);
      int   b = 0;
      int   k;
      vec_t x = t;
      while (!(t.sel ? rdy8 : rdy32) && b < 200) begin @(negedge clk); b++; end
      if (b >= 200) chk("ready_timeout", b, 0);
      k = t.sel ? (t.mode ? 12 : 8) : (t.mode ? 44 : 32);
      x.due = cyc + k + 2;
      if (t.sel) begin
         mode8 = t.mode; v8 = t.v[7:0]; bcdin8 = t.bcd_in[11:0]; signin8 = t.sign_in; start8 = 1'b1;
         if (push) q8.push_back(x);
      end else begin
         mode32 = t.mode; v32 = t.v; bcdin32 = t.bcd_in; signin32 = t.sign_in; start32 = 1'b1;
         if (push) q32.push_back(x);
      end
      @(negedge clk);
      start32 = 1'b0;
      start8  = 1'b0;
   endtask

   task automatic drain(input bit sel);
      int b = 0;
      while ((sel ? q8.size() : q32.size()) != 0 && b < 100) begin @(negedge clk); b++; end
      if (b >= 100) chk("drain_timeout", sel ? q8.size() : q32.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      rst32 = 1'b1; start32 = 1'b0; mode32 = 1'b0; v32 = '0; bcdin32 = '0; signin32 = 1'b0;
      rst8  = 1'b1; start8  = 1'b0; mode8  = 1'b0; v8  = '0; bcdin8  = '0; signin8  = 1'b0;

      // u32: N=32, D=11
      vecs.push_back(mk(0, 0, 32'hFF,       0, 0, 44'h255,         0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'hFFFFFFFF, 0, 0, 44'h04294967295, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 44'h0,           0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h00BC614E, 0, 0, 44'h00012345678, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h3B9ACA00, 0, 0, 44'h01000000000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'd10,       0, 0, 44'h10,          0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 44'h04294967295, 0, 0, 0, 32'hFFFFFFFF, 0, 0));
      vecs.push_back(mk(0, 1, 0, 44'h04294967296, 0, 0, 0, 32'h0,        1, 0));
      vecs.push_back(mk(0, 1, 0, 44'h99999999999, 0, 0, 0, 32'h4876E7FF, 1, 0));
      vecs.push_back(mk(0, 1, 0, 44'h0000000000A, 0, 0, 0, 32'h0,        0, 1));
      vecs.push_back(mk(0, 1, 0, 44'h00012345678, 0, 0, 0, 32'h00BC614E, 0, 0));
      vecs.push_back(mk(0, 1, 0, 44'h0,           0, 0, 0, 32'h0,        0, 0));
      // u8s: N=8, D=3, signed
      vecs.push_back(mk(1, 0, 32'h80, 0, 0, 44'h128, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'hF6, 0, 0, 44'h010, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h7F, 0, 0, 44'h127, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h00, 0, 0, 44'h000, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h63, 0, 0, 44'h099, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'hFF, 0, 0, 44'h001, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 44'h128, 1, 0, 0, 32'h80, 0, 0));
      vecs.push_back(mk(1, 1, 0, 44'h128, 0, 0, 0, 32'h80, 1, 0));
      vecs.push_back(mk(1, 1, 0, 44'h1A0, 0, 0, 0, 32'h00, 0, 1));
      vecs.push_back(mk(1, 1, 0, 44'h127, 0, 0, 0, 32'h7F, 0, 0));
      vecs.push_back(mk(1, 1, 0, 44'h127, 1, 0, 0, 32'h81, 0, 0));
      vecs.push_back(mk(1, 1, 0, 44'h000, 1, 0, 0, 32'h00, 0, 0));
      vecs.push_back(mk(1, 1, 0, 44'h999, 0, 0, 0, 32'hE7, 1, 0));
      vecs.push_back(mk(1, 1, 0, 44'h129, 1, 0, 0, 32'h7F, 1, 0));
      vecs.push_back(mk(1, 1, 0, 44'hF00, 1, 0, 0, 32'h00, 0, 1));

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst32 = 1'b0; rst8 = 1'b0;
      chk("rst_ready32", rdy32, 1); chk("rst_done32", done32, 0);
      chk("rst_bcd32", bcd32, 0);   chk("rst_bin32", bin32, 0);
      chk("rst_flags32", {sign32, ovf32, err32}, 0);
      chk("rst_ready8", rdy8, 1);   chk("rst_done8", done8, 0);
      chk("rst_out8", {bcd8, bin8, sign8, ovf8, err8}, 0);

      foreach (vecs[i]) begin
         drive(vecs[i], 1'b1);
         drain(vecs[i].sel);
      end

      // Results hold across conversions of the other mode.
      chk("u32_bcd_hold", bcd32, 44'h10);
      chk("u8_bcd_hold", bcd8, 12'h001);
      chk("u8_sign_hold", sign8, 1);

      // Back-to-back: new Start in the Done cycle.
      drive(mk(0, 0, 32'hFFFFFFFF, 0, 0, 44'h04294967295, 0, 0, 0, 0), 1'b1);
      b = 0;
      while (!done32 && b < 100) begin @(negedge clk); b++; end
      if (b >= 100) chk("b2b_done_timeout", b, 0);
      drive(mk(0, 0, 32'h0, 0, 0, 44'h0, 0, 0, 0, 0), 1'b1);
      drain(1'b0);

      // Start while busy is ignored: one Done, original result.
      drive(mk(0, 0, 32'hFF, 0, 0, 44'h255, 0, 0, 0, 0), 1'b1);
      repeat (3) @(negedge clk);
      chk("busy_ready_low", rdy32, 0);
      v32 = 32'h12345; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      drain(1'b0);
      repeat (40) @(negedge clk);
      chk("busy_no_extra", q32.size(), 0);

      // Reset 5 cycles into a conversion aborts it without a Done pulse.
      drive(mk(0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      repeat (4) @(negedge clk);
      chk("abort_busy", rdy32, 0);
      rst32 = 1'b1;
      @(negedge clk);
      rst32 = 1'b0;
      chk("abort_ready", rdy32, 1);
      chk("abort_done", done32, 0);
      chk("abort_bcd", bcd32, 0);
      chk("abort_flags", {sign32, ovf32, err32}, 0);
      repeat (40) @(negedge clk);
      chk("abort_idle", rdy32, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
